spi_target: RTL and testbench

- SPI responder (mode 0, MSB first, 8-bit): the far end of the register-driven SPI master on the DFB1 CPLD.
- Lets the DFB1 master talk to a bench or second CPLD over the P50/P61/P106/P110 header, and serves as the bus-functional peer for SD-card-style transfers.
- Oversamples SCK/CS/MOSI in the CLKOSC domain.
- Presents byte-wide rx/tx handshakes to local logic.

---
 rtl/spi_target.sv | 178 +++++++++++++++++
 tb/tb_spi_target.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// SPI mode-0 responder, MSB first, oversampled in the CLKOSC domain with byte-wide rx/tx handshakes.
// Define SPI_TARGET_TRISTATE_EN to float MISO (1'bz) in IDLE and reset for a shared MISO line.
module spi_target #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_FILL   = 8'hFF
) (
  input  logic             CLKOSC,
  input  logic             RST,
  input  logic             SCK,
  input  logic             CS,
  input  logic             MOSI,
  output logic             MISO,
  output logic             MISO_OE,
  input  logic [WIDTH-1:0] TX_DATA,
  input  logic             TX_VALID,
  output logic             TX_READY,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  input  logic             RX_ACK,
  output logic             RX_OVERRUN,
  output logic             TX_UNDERRUN,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;

  logic                   r_state;
  logic [CW-1:0]          r_bit_cnt;
  logic [WIDTH-2:0]       r_rx_shift;
  logic [WIDTH-1:0]       r_tx_shift;
  logic                   r_skip_fall;
  logic [WIDTH-1:0]       r_hold;
  logic                   r_hold_full;
  logic [WIDTH-1:0]       r_rx_data;
  logic                   r_rx_valid;
  logic                   r_rx_overrun;
  logic                   r_tx_underrun;

  logic                   w_sck_s;
  logic                   w_cs_s;
  logic                   w_mosi_s;
  logic                   w_sck_rise;
  logic                   w_sck_fall;
  logic                   w_cs_fall;
  logic                   w_start;
  logic                   w_byte_done;
  logic                   w_load;
  logic                   w_accept;
  logic [WIDTH-1:0]       w_load_data;
  logic [WIDTH-1:0]       w_rx_next;

  // CS flops reset low so a CS already held low at release never looks like a falling edge.
  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sck_d     <= w_sck_s;
      r_cs_d      <= w_cs_s;
    end
  end

  assign w_sck_s     = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise  = w_sck_s & ~r_sck_d;
  assign w_sck_fall  = ~w_sck_s & r_sck_d;
  assign w_cs_fall   = ~w_cs_s & r_cs_d;

  assign w_start     = (r_state == ST_IDLE) & w_cs_fall;
  assign w_byte_done = (r_state == ST_SHIFT) & ~w_cs_s & w_sck_rise &
                       (r_bit_cnt == CW'(WIDTH - 1));
  assign w_load      = w_start | w_byte_done;
  assign w_accept    = TX_VALID & ~r_hold_full;
  assign w_load_data = r_hold_full ? r_hold : IDLE_FILL;
  assign w_rx_next   = {r_rx_shift, w_mosi_s};

  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_rx_shift    <= '0;
      r_tx_shift    <= '0;
      r_skip_fall   <= 1'b0;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      // A byte offered on the load cycle with an empty holding register waits for the next byte.
      if (w_load && r_hold_full) begin
        r_hold_full <= 1'b0;
      end else if (w_accept) begin
        r_hold      <= TX_DATA;
        r_hold_full <= 1'b1;
      end
      if (w_load && !r_hold_full) begin
        r_tx_underrun <= 1'b1;
      end

      if (w_byte_done) begin
        r_rx_data  <= w_rx_next;
        r_rx_valid <= 1'b1;
        if (r_rx_valid && !RX_ACK) begin
          r_rx_overrun <= 1'b1;
        end
      end else if (RX_ACK) begin
        r_rx_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state    <= ST_SHIFT;
            r_tx_shift <= w_load_data;
          end
        end
        default: begin
          if (w_cs_s) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_skip_fall <= 1'b0;
          end else if (w_sck_rise) begin
            r_rx_shift <= w_rx_next[WIDTH-2:0];
            if (w_byte_done) begin
              r_bit_cnt   <= '0;
              r_tx_shift  <= w_load_data;
              r_skip_fall <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + CW'(1);
            end
          end else if (w_sck_fall) begin
            // The reload at a byte boundary already put the new MSB on MISO.
            if (r_skip_fall) begin
              r_skip_fall <= 1'b0;
            end else begin
              r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
            end
          end
        end
      endcase
    end
  end

  assign MISO_OE     = (r_state == ST_SHIFT);
  assign BUSY        = (r_state == ST_SHIFT);
  assign TX_READY    = ~r_hold_full;
  assign RX_DATA     = r_rx_data;
  assign RX_VALID    = r_rx_valid;
  assign RX_OVERRUN  = r_rx_overrun;
  assign TX_UNDERRUN = r_tx_underrun;

`ifdef SPI_TARGET_TRISTATE_EN
  assign MISO = (r_state == ST_SHIFT) ? r_tx_shift[WIDTH-1] : 1'bz;
`else
  assign MISO = (r_state == ST_SHIFT) ? r_tx_shift[WIDTH-1] : 1'b1;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a mode-0 master model drives SCK/CS/MOSI slowly
// (8 CLKOSC cycles per SCK phase) and each scenario task checks its own results.
module tb_spi_target;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sck = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       rx_overrun;
  logic       tx_underrun;
  logic       busy;

  int total = 0;
  int bad   = 0;

`ifdef SPI_TARGET_TRISTATE_EN
  localparam logic EXP_IDLE_MISO = 1'bz;
`else
  localparam logic EXP_IDLE_MISO = 1'b1;
`endif

  spi_target dut (
    .CLKOSC      (clk),
    .RST         (rst),
    .SCK         (sck),
    .CS          (cs),
    .MOSI        (mosi),
    .MISO        (miso),
    .MISO_OE     (miso_oe),
    .TX_DATA     (tx_data),
    .TX_VALID    (tx_valid),
    .TX_READY    (tx_ready),
    .RX_DATA     (rx_data),
    .RX_VALID    (rx_valid),
    .RX_ACK      (rx_ack),
    .RX_OVERRUN  (rx_overrun),
    .TX_UNDERRUN (tx_underrun),
    .BUSY        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
  endtask

  task automatic queue_tx(input logic [7:0] b);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 32) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL tx_ready_wait got=%b exp=1", tx_ready);
    end else begin
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
    end
  endtask

  task automatic ack_rx;
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic cs_low;
    cs = 1'b0;
    tick(8);
  endtask

  task automatic cs_high;
    tick(8);
    cs = 1'b1;
    tick(8);
  endtask

  // Master samples MISO just before each rising SCK; optional refill during the first high phase.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input logic refill,
                          input logic [7:0] rb, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      tick(8);
      rx[7-i] = miso;
      sck = 1'b1;
      if (refill && i == 0) begin
        tick(2);
        queue_tx(rb);
        tick(5);
      end else begin
        tick(8);
      end
      sck = 1'b0;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({miso_oe, tx_ready, rx_valid, rx_overrun, tx_underrun, busy} !== 6'b010000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=010000",
               {miso_oe, tx_ready, rx_valid, rx_overrun, tx_underrun, busy});
    end
    total++;
    if (rx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_rx_data got=%h exp=00", rx_data);
    end
    total++;
    if (miso !== EXP_IDLE_MISO) begin
      bad++;
      $display("FAIL reset_miso got=%b exp=%b", miso, EXP_IDLE_MISO);
    end
    tick(2);
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_single;
    logic [7:0] rd;
    do_reset();
    queue_tx(8'h3C);
    total++;
    if (tx_ready !== 1'b0) begin
      bad++;
      $display("FAIL single_hold_full got=%b exp=0", tx_ready);
    end
    cs_low();
    total++;
    if ({miso_oe, busy, tx_ready, tx_underrun} !== 4'b1110) begin
      bad++;
      $display("FAIL single_selected got=%b exp=1110", {miso_oe, busy, tx_ready, tx_underrun});
    end
    spi_bits(8'hA5, 8, 1'b1, 8'h00, rd);
    total++;
    if (rd !== 8'h3C) begin
      bad++;
      $display("FAIL single_miso_byte got=%h exp=3c", rd);
    end
    total++;
    if (rx_data !== 8'hA5 || rx_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_rx got=%h/%b exp=a5/1", rx_data, rx_valid);
    end
    total++;
    if (tx_underrun !== 1'b0 || rx_overrun !== 1'b0) begin
      bad++;
      $display("FAIL single_flags got=%b%b exp=00", tx_underrun, rx_overrun);
    end
    cs_high();
    total++;
    if (miso_oe !== 1'b0 || busy !== 1'b0 || miso !== EXP_IDLE_MISO) begin
      bad++;
      $display("FAIL single_idle got=%b%b%b exp=00%b", miso_oe, busy, miso, EXP_IDLE_MISO);
    end
  endtask

  task automatic test_underrun;
    logic [7:0] rd;
    do_reset();
    cs_low();
    spi_bits(8'h00, 8, 1'b0, 8'h00, rd);
    cs_high();
    total++;
    if (rd !== 8'hFF) begin
      bad++;
      $display("FAIL underrun_miso_byte got=%h exp=ff", rd);
    end
    total++;
    if (tx_underrun !== 1'b1) begin
      bad++;
      $display("FAIL underrun_flag got=%b exp=1", tx_underrun);
    end
    total++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b1) begin
      bad++;
      $display("FAIL underrun_rx got=%h/%b exp=00/1", rx_data, rx_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] mo[3]  = '{8'h01, 8'h02, 8'h03};
    logic [7:0] exp[3] = '{8'h10, 8'h20, 8'h30};
    logic [7:0] rf[3]  = '{8'h20, 8'h30, 8'h5A};
    logic [7:0] rd;
    do_reset();
    queue_tx(8'h10);
    cs_low();
    for (int k = 0; k < 3; k++) begin
      spi_bits(mo[k], 8, 1'b1, rf[k], rd);
      total++;
      if (rd !== exp[k]) begin
        bad++;
        $display("FAIL b2b_miso_%0d got=%h exp=%h", k, rd, exp[k]);
      end
      total++;
      if (rx_data !== mo[k] || rx_valid !== 1'b1) begin
        bad++;
        $display("FAIL b2b_rx_%0d got=%h/%b exp=%h/1", k, rx_data, rx_valid, mo[k]);
      end
      ack_rx();
      total++;
      if (rx_valid !== 1'b0) begin
        bad++;
        $display("FAIL b2b_ack_%0d got=%b exp=0", k, rx_valid);
      end
    end
    cs_high();
    total++;
    if ({rx_overrun, tx_underrun} !== 2'b00) begin
      bad++;
      $display("FAIL b2b_flags got=%b exp=00", {rx_overrun, tx_underrun});
    end
  endtask

  task automatic test_overrun;
    logic [7:0] rd;
    do_reset();
    cs_low();
    spi_bits(8'h55, 8, 1'b0, 8'h00, rd);
    total++;
    if (rx_data !== 8'h55 || rx_overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_first got=%h/%b exp=55/0", rx_data, rx_overrun);
    end
    spi_bits(8'hAA, 8, 1'b0, 8'h00, rd);
    cs_high();
    total++;
    if (rx_data !== 8'hAA || rx_valid !== 1'b1 || rx_overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_second got=%h/%b/%b exp=aa/1/1", rx_data, rx_valid, rx_overrun);
    end
  endtask

  task automatic test_cs_abort;
    logic [7:0] rd;
    do_reset();
    cs_low();
    spi_bits(8'hF0, 4, 1'b0, 8'h00, rd);
    cs_high();
    total++;
    if (rx_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_partial got=%b/%b exp=0/0", rx_valid, busy);
    end
    cs_low();
    spi_bits(8'h81, 8, 1'b0, 8'h00, rd);
    cs_high();
    total++;
    if (rx_data !== 8'h81 || rx_valid !== 1'b1 || rx_overrun !== 1'b0) begin
      bad++;
      $display("FAIL abort_full got=%h/%b/%b exp=81/1/0", rx_data, rx_valid, rx_overrun);
    end
  endtask

  task automatic test_rst_mid;
    logic [7:0] rd;
    cs_low();
    spi_bits(8'hE7, 5, 1'b1, 8'h77, rd);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({miso_oe, busy, tx_ready, rx_valid, rx_overrun, tx_underrun} !== 6'b001000) begin
      bad++;
      $display("FAIL rstmid_flags got=%b exp=001000",
               {miso_oe, busy, tx_ready, rx_valid, rx_overrun, tx_underrun});
    end
    total++;
    if (rx_data !== 8'h00 || miso !== EXP_IDLE_MISO) begin
      bad++;
      $display("FAIL rstmid_data got=%h/%b exp=00/%b", rx_data, miso, EXP_IDLE_MISO);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(16);
    total++;
    if (busy !== 1'b0 || miso_oe !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_no_join got=%b/%b exp=0/0", busy, miso_oe);
    end
    cs = 1'b1;
    tick(8);
    cs_low();
    spi_bits(8'hC3, 8, 1'b0, 8'h00, rd);
    cs_high();
    total++;
    if (rx_data !== 8'hC3 || rx_valid !== 1'b1 || rd !== 8'hFF) begin
      bad++;
      $display("FAIL rstmid_next got=%h/%b/%h exp=c3/1/ff", rx_data, rx_valid, rd);
    end
  endtask

  initial begin
    tick(3);
    test_reset();
    test_single();
    test_underrun();
    test_back_to_back();
    test_overrun();
    test_cs_abort();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
